model_config_mem: RTL and testbench

Responder side of the model-configuration read interface. Holds per-layer forward and backward compute costs plus three scalar scheduling constants (NPU capability, in-pipeline CIM capability, bubble threshold). Serves single-word reads from the inter-layer block scheduler through a valid/ready pulse handshake and accepts host writes for model loading. The scalar constants are also driven continuously to the scheduler.

---
 rtl/model_config_mem.sv | 272 +++++++++++++++++++++++++++
 tb/tb_model_config_mem.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/model_config_mem.sv
// -----------------------------------------------------------------------------
// model_config_mem
//
// Responder for the model-configuration read interface. Stores per-layer
// forward and backward compute costs (two DEPTH-word arrays) and three scalar
// scheduling constants. Serves single-word reads via a valid/ready pulse
// handshake with a fixed LATENCY, and accepts host writes at any time.
//
// Address map (same for reads and writes):
//    [31:16] must be 0
//    region 0x00 : forward compute array, index < DEPTH
//    region 0x01 : backward compute array, index < DEPTH
//    region 0x02 : scalar registers, index 0..2
//    anything else is unmapped (reads return 0 + addr_err_o, writes dropped)
//
// Ports:
//    clk_i, rst_ni                    clock, asynchronous active-low reset
//    config_mem_addr_i [31:0]         read address
//    config_mem_read_valid_i          read request
//    config_mem_read_data_o [31:0]    registered read data, held between responses
//    config_mem_read_ready_o          one-cycle response pulse
//    addr_err_o                       one-cycle pulse with ready on unmapped read
//    wr_en_i, wr_addr_i, wr_data_i    host write port
//    npu_capability_o                 scalar register 0
//    in_pipeline_cim_capability_o     scalar register 1
//    bubble_threshold_o               scalar register 2
//    parity_err_o                     sticky parity error (MODEL_CONFIG_MEM_PARITY_EN only)
//
// Optional feature: define MODEL_CONFIG_MEM_PARITY_EN to store an even-parity
// bit per word and check it on every response.
// -----------------------------------------------------------------------------
module model_config_mem #(
   parameter int LATENCY = 2,
   parameter int DEPTH   = 256
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [31:0] config_mem_addr_i,
   input  logic        config_mem_read_valid_i,
   output logic [31:0] config_mem_read_data_o,
   output logic        config_mem_read_ready_o,
   output logic        addr_err_o,
   input  logic        wr_en_i,
   input  logic [31:0] wr_addr_i,
   input  logic [31:0] wr_data_i,
   output logic [31:0] npu_capability_o,
   output logic [31:0] in_pipeline_cim_capability_o,
`ifdef MODEL_CONFIG_MEM_PARITY_EN
   output logic [31:0] bubble_threshold_o,
   output logic        parity_err_o
`else
   output logic [31:0] bubble_threshold_o
`endif
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP,
      S_HOLD
   } state_t;

   // ---------------------------------------------------------------------
   // Storage
   // ---------------------------------------------------------------------
   logic [31:0] r_fwd_mem [DEPTH];
   logic [31:0] r_bwd_mem [DEPTH];
   logic [31:0] r_npu;
   logic [31:0] r_cim;
   logic [31:0] r_bubble;
`ifdef MODEL_CONFIG_MEM_PARITY_EN
   logic [DEPTH-1:0] r_fwd_par;
   logic [DEPTH-1:0] r_bwd_par;
   logic [2:0]       r_scl_par;
   logic             r_parity_err;
`endif

   // ---------------------------------------------------------------------
   // Read FSM state
   // ---------------------------------------------------------------------
   state_t      r_state;
   logic [2:0]  r_cnt;
   logic [31:0] r_addr;
   logic [31:0] r_data;
   logic        r_ready;
   logic        r_err;

   // ---------------------------------------------------------------------
   // Address decode: read side uses the captured address, write side the
   // live host address.
   // ---------------------------------------------------------------------
   logic       w_rd_fwd, w_rd_bwd, w_rd_scl, w_rd_mapped;
   logic       w_wr_fwd, w_wr_bwd, w_wr_scl;
   logic [7:0] w_rd_index;
   logic [7:0] w_wr_index;

   assign w_rd_index = r_addr[7:0];
   assign w_wr_index = wr_addr_i[7:0];

   // 9-bit compare so DEPTH=256 covers every 8-bit index
   assign w_rd_fwd = (r_addr[31:16] == 16'h0) && (r_addr[15:8] == 8'h00)
                     && ({1'b0, w_rd_index} < 9'(DEPTH));
   assign w_rd_bwd = (r_addr[31:16] == 16'h0) && (r_addr[15:8] == 8'h01)
                     && ({1'b0, w_rd_index} < 9'(DEPTH));
   assign w_rd_scl = (r_addr[31:16] == 16'h0) && (r_addr[15:8] == 8'h02)
                     && (w_rd_index < 8'd3);
   assign w_rd_mapped = w_rd_fwd | w_rd_bwd | w_rd_scl;

   assign w_wr_fwd = (wr_addr_i[31:16] == 16'h0) && (wr_addr_i[15:8] == 8'h00)
                     && ({1'b0, w_wr_index} < 9'(DEPTH));
   assign w_wr_bwd = (wr_addr_i[31:16] == 16'h0) && (wr_addr_i[15:8] == 8'h01)
                     && ({1'b0, w_wr_index} < 9'(DEPTH));
   assign w_wr_scl = (wr_addr_i[31:16] == 16'h0) && (wr_addr_i[15:8] == 8'h02)
                     && (w_wr_index < 8'd3);

   // ---------------------------------------------------------------------
   // Read mux (unmapped addresses read as zero)
   // ---------------------------------------------------------------------
   logic [31:0] w_rd_data;
   logic        w_rd_par;

   always_comb begin
      w_rd_data = '0;
      w_rd_par  = 1'b0;
      if (w_rd_fwd) begin
         w_rd_data = r_fwd_mem[w_rd_index[AW-1:0]];
`ifdef MODEL_CONFIG_MEM_PARITY_EN
         w_rd_par  = r_fwd_par[w_rd_index[AW-1:0]];
`endif
      end else if (w_rd_bwd) begin
         w_rd_data = r_bwd_mem[w_rd_index[AW-1:0]];
`ifdef MODEL_CONFIG_MEM_PARITY_EN
         w_rd_par  = r_bwd_par[w_rd_index[AW-1:0]];
`endif
      end else if (w_rd_scl) begin
         case (w_rd_index[1:0])
            2'd0:    w_rd_data = r_npu;
            2'd1:    w_rd_data = r_cim;
            default: w_rd_data = r_bubble;
         endcase
`ifdef MODEL_CONFIG_MEM_PARITY_EN
         case (w_rd_index[1:0])
            2'd0:    w_rd_par = r_scl_par[0];
            2'd1:    w_rd_par = r_scl_par[1];
            default: w_rd_par = r_scl_par[2];
         endcase
`endif
      end
   end

   // ---------------------------------------------------------------------
   // Host writes: single cycle, independent of the read FSM. Because both
   // the array write and the RESP data capture are non-blocking on the same
   // edge, a same-address collision returns the old word.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_fwd_mem[i] <= '0;
            r_bwd_mem[i] <= '0;
         end
         r_npu    <= '0;
         r_cim    <= '0;
         r_bubble <= '0;
`ifdef MODEL_CONFIG_MEM_PARITY_EN
         r_fwd_par <= '0;
         r_bwd_par <= '0;
         r_scl_par <= '0;
`endif
      end else if (wr_en_i) begin
         if (w_wr_fwd) begin
            r_fwd_mem[w_wr_index[AW-1:0]] <= wr_data_i;
`ifdef MODEL_CONFIG_MEM_PARITY_EN
            r_fwd_par[w_wr_index[AW-1:0]] <= ^wr_data_i;
`endif
         end
         if (w_wr_bwd) begin
            r_bwd_mem[w_wr_index[AW-1:0]] <= wr_data_i;
`ifdef MODEL_CONFIG_MEM_PARITY_EN
            r_bwd_par[w_wr_index[AW-1:0]] <= ^wr_data_i;
`endif
         end
         if (w_wr_scl) begin
            case (w_wr_index[1:0])
               2'd0:    r_npu    <= wr_data_i;
               2'd1:    r_cim    <= wr_data_i;
               default: r_bubble <= wr_data_i;
            endcase
`ifdef MODEL_CONFIG_MEM_PARITY_EN
            case (w_wr_index[1:0])
               2'd0:    r_scl_par[0] <= ^wr_data_i;
               2'd1:    r_scl_par[1] <= ^wr_data_i;
               default: r_scl_par[2] <= ^wr_data_i;
            endcase
`endif
         end
      end
   end

   // ---------------------------------------------------------------------
   // Read FSM. HOLD exists because the requester registers ready and keeps
   // its stale request up for one more cycle; serving it would duplicate
   // the response.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_data  <= '0;
         r_ready <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_ready <= 1'b0;
         r_err   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (config_mem_read_valid_i) begin
                  r_addr <= config_mem_addr_i;
                  if (LATENCY == 1) begin
                     r_state <= S_RESP;
                  end else begin
                     // WAIT lasts LATENCY-1 cycles; counter exits at zero
                     r_cnt   <= 3'(LATENCY - 2);
                     r_state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (r_cnt == 3'd0) begin
                  r_state <= S_RESP;
               end else begin
                  r_cnt <= r_cnt - 3'd1;
               end
            end
            S_RESP: begin
               r_data  <= w_rd_data;
               r_ready <= 1'b1;
               r_err   <= ~w_rd_mapped;
               r_state <= S_HOLD;
            end
            S_HOLD: begin
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef MODEL_CONFIG_MEM_PARITY_EN
   // Sticky: any odd-parity word seen on a mapped response latches the flag
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_parity_err <= 1'b0;
      end else if ((r_state == S_RESP) && w_rd_mapped && (^{w_rd_data, w_rd_par})) begin
         r_parity_err <= 1'b1;
      end
   end

   assign parity_err_o = r_parity_err;
`endif

   assign config_mem_read_data_o       = r_data;
   assign config_mem_read_ready_o      = r_ready;
   assign addr_err_o                   = r_err;
   assign npu_capability_o             = r_npu;
   assign in_pipeline_cim_capability_o = r_cim;
   assign bubble_threshold_o           = r_bubble;

endmodule

// File: tb/tb_model_config_mem.sv
// -----------------------------------------------------------------------------
// tb_model_config_mem
//
// Directed self-checking bench for model_config_mem (LATENCY=2, DEPTH=256).
// Each scenario task drives its stimulus and compares against hand-computed
// values. Inputs change 1 time unit after the rising edge and outputs are
// sampled at the same point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_model_config_mem;

   logic        clk_i;
   logic        rst_ni;
   logic [31:0] config_mem_addr_i;
   logic        config_mem_read_valid_i;
   logic [31:0] config_mem_read_data_o;
   logic        config_mem_read_ready_o;
   logic        addr_err_o;
   logic        wr_en_i;
   logic [31:0] wr_addr_i;
   logic [31:0] wr_data_i;
   logic [31:0] npu_capability_o;
   logic [31:0] in_pipeline_cim_capability_o;
   logic [31:0] bubble_threshold_o;
`ifdef MODEL_CONFIG_MEM_PARITY_EN
   logic        parity_err_o;
`endif

   int total_cnt = 0;
   int pass_cnt  = 0;

   model_config_mem #(
      .LATENCY(2),
      .DEPTH(256)
   ) dut (
      .clk_i                        (clk_i),
      .rst_ni                       (rst_ni),
      .config_mem_addr_i            (config_mem_addr_i),
      .config_mem_read_valid_i      (config_mem_read_valid_i),
      .config_mem_read_data_o       (config_mem_read_data_o),
      .config_mem_read_ready_o      (config_mem_read_ready_o),
      .addr_err_o                   (addr_err_o),
      .wr_en_i                      (wr_en_i),
      .wr_addr_i                    (wr_addr_i),
      .wr_data_i                    (wr_data_i),
      .npu_capability_o             (npu_capability_o),
      .in_pipeline_cim_capability_o (in_pipeline_cim_capability_o),
`ifdef MODEL_CONFIG_MEM_PARITY_EN
      .bubble_threshold_o           (bubble_threshold_o),
      .parity_err_o                 (parity_err_o)
`else
      .bubble_threshold_o           (bubble_threshold_o)
`endif
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
      wr_en_i   = 1'b1;
      wr_addr_i = addr;
      wr_data_i = data;
      step();
      wr_en_i   = 1'b0;
      wr_addr_i = '0;
      wr_data_i = '0;
   endtask

   // Issues one request, waits (bounded) for ready, then steps through HOLD.
   // n = edges after acceptance until ready (10 means it never came).
   task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic err, output int n, output logic rdy_h,
                          output logic err_h, output logic [31:0] data_h);
      config_mem_addr_i       = addr;
      config_mem_read_valid_i = 1'b1;
      step();
      config_mem_read_valid_i = 1'b0;
      config_mem_addr_i       = 32'hFFFF_FFFF;  // the captured address must be used
      n = 0;
      while (config_mem_read_ready_o !== 1'b1 && n < 10) begin
         step();
         n++;
      end
      data = config_mem_read_data_o;
      err  = addr_err_o;
      step();
      rdy_h  = config_mem_read_ready_o;
      err_h  = addr_err_o;
      data_h = config_mem_read_data_o;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      config_mem_addr_i = '0;
      config_mem_read_valid_i = 1'b0;
      wr_en_i = 1'b0;
      wr_addr_i = '0;
      wr_data_i = '0;
      step();
      step();
      total_cnt++;
      if (config_mem_read_data_o !== 32'h0) $display("FAIL reset_data: got %h want 0", config_mem_read_data_o);
      else pass_cnt++;
      total_cnt++;
      if (config_mem_read_ready_o !== 1'b0) $display("FAIL reset_ready: got %b want 0", config_mem_read_ready_o);
      else pass_cnt++;
      total_cnt++;
      if (addr_err_o !== 1'b0) $display("FAIL reset_err: got %b want 0", addr_err_o);
      else pass_cnt++;
      total_cnt++;
      if (npu_capability_o !== 32'h0) $display("FAIL reset_npu: got %h want 0", npu_capability_o);
      else pass_cnt++;
      total_cnt++;
      if (in_pipeline_cim_capability_o !== 32'h0) $display("FAIL reset_cim: got %h want 0", in_pipeline_cim_capability_o);
      else pass_cnt++;
      total_cnt++;
      if (bubble_threshold_o !== 32'h0) $display("FAIL reset_bubble: got %h want 0", bubble_threshold_o);
      else pass_cnt++;
`ifdef MODEL_CONFIG_MEM_PARITY_EN
      total_cnt++;
      if (parity_err_o !== 1'b0) $display("FAIL reset_parity: got %b want 0", parity_err_o);
      else pass_cnt++;
`endif
      rst_ni = 1'b1;
      step();
      $display("test_reset done");
   endtask

   task automatic test_first_read();
      logic [31:0] d, dh;
      logic e, rh, eh;
      int n;
      do_read(32'h0000_0200, d, e, n, rh, eh, dh);
      $display("read 0x0200: data=%h err=%b latency=%0d", d, e, n);
      total_cnt++;
      if (n !== 2) $display("FAIL first_latency: got %0d want 2", n);
      else pass_cnt++;
      total_cnt++;
      if (d !== 32'h0) $display("FAIL first_data: got %h want 0", d);
      else pass_cnt++;
      total_cnt++;
      if (e !== 1'b0) $display("FAIL first_err: got %b want 0", e);
      else pass_cnt++;
      total_cnt++;
      if (rh !== 1'b0) $display("FAIL first_ready_one_cycle: got %b want 0", rh);
      else pass_cnt++;
   endtask

   task automatic test_write_read();
      logic [31:0] d, dh;
      logic e, rh, eh;
      int n;
      do_write(32'h0000_0105, 32'h0000_1234);
      do_write(32'h0000_0000, 32'hDEAD_BEEF);
      // scalar write: output must still be old before the edge, new after it
      wr_en_i   = 1'b1;
      wr_addr_i = 32'h0000_0201;
      wr_data_i = 32'd7;
      #1;
      total_cnt++;
      if (in_pipeline_cim_capability_o !== 32'h0) $display("FAIL cim_before_edge: got %h want 0", in_pipeline_cim_capability_o);
      else pass_cnt++;
      step();
      wr_en_i = 1'b0;
      total_cnt++;
      if (in_pipeline_cim_capability_o !== 32'd7) $display("FAIL cim_after_write: got %h want 7", in_pipeline_cim_capability_o);
      else pass_cnt++;
      do_write(32'h0000_0200, 32'h0000_0011);
      do_write(32'h0000_0202, 32'h0000_0022);
      total_cnt++;
      if (npu_capability_o !== 32'h11) $display("FAIL npu_write: got %h want 11", npu_capability_o);
      else pass_cnt++;
      total_cnt++;
      if (bubble_threshold_o !== 32'h22) $display("FAIL bubble_write: got %h want 22", bubble_threshold_o);
      else pass_cnt++;

      do_read(32'h0000_0105, d, e, n, rh, eh, dh);
      $display("read 0x0105: data=%h err=%b latency=%0d", d, e, n);
      total_cnt++;
      if (d !== 32'h1234 || e !== 1'b0) $display("FAIL bwd_read: got %h/%b want 00001234/0", d, e);
      else pass_cnt++;
      total_cnt++;
      if (dh !== 32'h1234) $display("FAIL bwd_hold_data: got %h want 00001234", dh);
      else pass_cnt++;

      do_read(32'h0000_0000, d, e, n, rh, eh, dh);
      $display("read 0x0000: data=%h err=%b latency=%0d", d, e, n);
      total_cnt++;
      if (d !== 32'hDEAD_BEEF) $display("FAIL fwd_read: got %h want deadbeef", d);
      else pass_cnt++;

      do_read(32'h0000_0201, d, e, n, rh, eh, dh);
      $display("read 0x0201: data=%h err=%b latency=%0d", d, e, n);
      total_cnt++;
      if (d !== 32'd7 || e !== 1'b0) $display("FAIL scalar_read: got %h/%b want 00000007/0", d, e);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic exp_rdy;
      int pulses;
      do_write(32'h0000_0003, 32'h0000_CAFE);
      pulses = 0;
      config_mem_addr_i       = 32'h0000_0003;
      config_mem_read_valid_i = 1'b1;
      // accept at edge 0, ready after edges 2, 6, 10, 14, 18
      for (int i = 0; i < 20; i++) begin
         step();
         exp_rdy = ((i % 4) == 2);
         if (config_mem_read_ready_o === 1'b1) pulses++;
         total_cnt++;
         if (config_mem_read_ready_o !== exp_rdy)
            $display("FAIL b2b_ready_cycle%0d: got %b want %b", i, config_mem_read_ready_o, exp_rdy);
         else pass_cnt++;
         if (exp_rdy) begin
            total_cnt++;
            if (config_mem_read_data_o !== 32'hCAFE)
               $display("FAIL b2b_data_cycle%0d: got %h want 0000cafe", i, config_mem_read_data_o);
            else pass_cnt++;
         end
      end
      config_mem_read_valid_i = 1'b0;
      $display("back_to_back: %0d ready pulses in 20 cycles", pulses);
      total_cnt++;
      if (pulses !== 5) $display("FAIL b2b_pulse_count: got %0d want 5", pulses);
      else pass_cnt++;
      step();
      step();
   endtask

   task automatic test_unmapped();
      logic [31:0] d, dh;
      logic e, rh, eh;
      int n;
      do_read(32'h0000_0300, d, e, n, rh, eh, dh);
      $display("read 0x0300: data=%h err=%b latency=%0d", d, e, n);
      total_cnt++;
      if (d !== 32'h0 || e !== 1'b1 || n !== 2) $display("FAIL unmapped_region: got %h/%b/%0d want 0/1/2", d, e, n);
      else pass_cnt++;
      total_cnt++;
      if (eh !== 1'b0) $display("FAIL unmapped_err_one_cycle: got %b want 0", eh);
      else pass_cnt++;

      do_read(32'h0001_0000, d, e, n, rh, eh, dh);
      $display("read 0x10000: data=%h err=%b latency=%0d", d, e, n);
      total_cnt++;
      if (d !== 32'h0 || e !== 1'b1) $display("FAIL unmapped_upper: got %h/%b want 0/1", d, e);
      else pass_cnt++;

      do_read(32'h0000_0203, d, e, n, rh, eh, dh);
      $display("read 0x0203: data=%h err=%b latency=%0d", d, e, n);
      total_cnt++;
      if (d !== 32'h0 || e !== 1'b1) $display("FAIL unmapped_scalar3: got %h/%b want 0/1", d, e);
      else pass_cnt++;

      do_write(32'h0000_0203, 32'hFFFF_FFFF);
      do_write(32'h0001_0005, 32'h0000_0077);
      total_cnt++;
      if (npu_capability_o !== 32'h11 || in_pipeline_cim_capability_o !== 32'd7 || bubble_threshold_o !== 32'h22)
         $display("FAIL unmapped_write_scalars: got %h/%h/%h want 11/7/22",
                  npu_capability_o, in_pipeline_cim_capability_o, bubble_threshold_o);
      else pass_cnt++;

      do_read(32'h0000_0005, d, e, n, rh, eh, dh);
      $display("read 0x0005: data=%h err=%b latency=%0d", d, e, n);
      total_cnt++;
      if (d !== 32'h0 || e !== 1'b0) $display("FAIL unmapped_write_alias: got %h/%b want 0/0", d, e);
      else pass_cnt++;
   endtask

   task automatic test_read_before_write();
      logic [31:0] d, dh;
      logic e, rh, eh;
      int n;
      do_write(32'h0000_0010, 32'h0000_0055);
      config_mem_addr_i       = 32'h0000_0010;
      config_mem_read_valid_i = 1'b1;
      step();                               // accepted, now WAIT
      config_mem_read_valid_i = 1'b0;
      step();                               // now RESP
      wr_en_i   = 1'b1;
      wr_addr_i = 32'h0000_0010;
      wr_data_i = 32'h0000_00AA;
      step();                               // RESP edge: read + write collide
      wr_en_i = 1'b0;
      $display("rbw collision read 0x0010: data=%h ready=%b", config_mem_read_data_o, config_mem_read_ready_o);
      total_cnt++;
      if (config_mem_read_ready_o !== 1'b1) $display("FAIL rbw_ready: got %b want 1", config_mem_read_ready_o);
      else pass_cnt++;
      total_cnt++;
      if (config_mem_read_data_o !== 32'h55) $display("FAIL rbw_old_data: got %h want 00000055", config_mem_read_data_o);
      else pass_cnt++;
      step();                               // HOLD
      do_read(32'h0000_0010, d, e, n, rh, eh, dh);
      $display("read 0x0010: data=%h err=%b latency=%0d", d, e, n);
      total_cnt++;
      if (d !== 32'hAA) $display("FAIL rbw_new_data: got %h want 000000aa", d);
      else pass_cnt++;
   endtask

   task automatic test_reset_abort();
      logic [31:0] d, dh;
      logic e, rh, eh;
      int n;
      int seen;
      config_mem_addr_i       = 32'h0000_0105;
      config_mem_read_valid_i = 1'b1;
      step();                               // accepted, now WAIT
      config_mem_read_valid_i = 1'b0;
      rst_ni = 1'b0;
      #1;
      total_cnt++;
      if (config_mem_read_data_o !== 32'h0 || config_mem_read_ready_o !== 1'b0 || addr_err_o !== 1'b0)
         $display("FAIL abort_outputs: got %h/%b/%b want 0/0/0", config_mem_read_data_o, config_mem_read_ready_o, addr_err_o);
      else pass_cnt++;
      total_cnt++;
      if (npu_capability_o !== 32'h0 || in_pipeline_cim_capability_o !== 32'h0 || bubble_threshold_o !== 32'h0)
         $display("FAIL abort_scalars: got %h/%h/%h want 0/0/0",
                  npu_capability_o, in_pipeline_cim_capability_o, bubble_threshold_o);
      else pass_cnt++;
      step();
      rst_ni = 1'b1;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (config_mem_read_ready_o === 1'b1) seen++;
      end
      total_cnt++;
      if (seen !== 0) $display("FAIL abort_no_ready: got %0d pulses want 0", seen);
      else pass_cnt++;
      do_read(32'h0000_0105, d, e, n, rh, eh, dh);
      $display("post-reset read 0x0105: data=%h err=%b latency=%0d", d, e, n);
      total_cnt++;
      if (n !== 2 || d !== 32'h0 || e !== 1'b0) $display("FAIL abort_recover: got %h/%b/%0d want 0/0/2", d, e, n);
      else pass_cnt++;
   endtask

`ifdef MODEL_CONFIG_MEM_PARITY_EN
   task automatic test_parity();
      logic [31:0] d, dh;
      logic e, rh, eh;
      int n;
      do_write(32'h0000_0005, 32'h0000_0003);   // even parity bit 0
      do_read(32'h0000_0005, d, e, n, rh, eh, dh);
      total_cnt++;
      if (parity_err_o !== 1'b0) $display("FAIL parity_clean: got %b want 0", parity_err_o);
      else pass_cnt++;
      force dut.r_fwd_par[5] = 1'b1;
      do_read(32'h0000_0005, d, e, n, rh, eh, dh);
      release dut.r_fwd_par[5];
      $display("parity read 0x0005: data=%h parity_err=%b", d, parity_err_o);
      total_cnt++;
      if (d !== 32'h3) $display("FAIL parity_data: got %h want 00000003", d);
      else pass_cnt++;
      total_cnt++;
      if (parity_err_o !== 1'b1) $display("FAIL parity_set: got %b want 1", parity_err_o);
      else pass_cnt++;
      do_read(32'h0000_0200, d, e, n, rh, eh, dh);
      total_cnt++;
      if (parity_err_o !== 1'b1) $display("FAIL parity_sticky: got %b want 1", parity_err_o);
      else pass_cnt++;
   endtask
`endif

   initial begin
      test_reset();
      test_first_read();
      test_write_read();
      test_back_to_back();
      test_unmapped();
      test_read_before_write();
      test_reset_abort();
`ifdef MODEL_CONFIG_MEM_PARITY_EN
      test_parity();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   // Absolute guard so the run always ends
   initial begin
      #200000;
      $display("FAIL timeout: simulation still running at %0t, want finished", $time);
      $fatal(1, "timeout");
   end

endmodule
